// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Brief    : Synchronises a raw switch level and debounces it with a stability
//            counter. Optional RISE/FALL pulses are built when
//            SWITCH_DEBOUNCE_EDGE_EN is defined; otherwise they are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic I,
    output logic O,
    output logic RISE,
    output logic FALL
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_o;

    logic w_s;
    logic w_differ;
    logic w_take;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_s != r_o);
    assign w_take   = w_differ && (r_cnt == c_CNT_LAST);

    // The counter only runs while s disagrees with O, so it can never pass
    // c_CNT_LAST: that value either commits the new level or s falls back.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_o    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], I};
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_cnt <= '0;
                r_o   <= w_s;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign O = r_o;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered alongside O so they line up with its new value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_take && w_s;
            r_fall <= w_take && !w_s;
        end
    end

    assign RISE = r_rise;
    assign FALL = r_fall;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce
// Brief    : Directed + randomized bench for switch_debounce (DEBOUNCE_CYCLES
//            4 and 1) against a history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int SYNC  = 2;
    localparam int DEB_A = 4;
    localparam int DEB_B = 1;
    localparam int CW    = 16;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGES = 1'b1;
`else
    localparam bit EDGES = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    logic I;
    logic o_a, rise_a, fall_a;
    logic o_b, rise_b, fall_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: s is I delayed through SYNC samples; O flips once the
    // most recent DEB samples of s (since reset) all disagree with O.
    bit sync_q[$];
    bit hist_a[$];
    bit hist_b[$];
    bit mo_a, mr_a, mf_a, mo_b, mr_b, mf_b;
    int mc_a, mc_b;

    switch_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB_A), .CNT_WIDTH(CW)) dut_a (
        .CLK(CLK), .RESET(RESET), .I(I), .O(o_a), .RISE(rise_a), .FALL(fall_a)
    );

    switch_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB_B), .CNT_WIDTH(CW)) dut_b (
        .CLK(CLK), .RESET(RESET), .I(I), .O(o_b), .RISE(rise_b), .FALL(fall_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int run_len(input bit q[$], input bit o);
        int n;
        n = 0;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k] == o) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_edge(input bit r, input bit i);
        bit s;
        int n;
        mr_a = 1'b0; mf_a = 1'b0; mr_b = 1'b0; mf_b = 1'b0;
        if (r) begin
            sync_q.delete();
            repeat (SYNC) sync_q.push_back(1'b0);
            hist_a.delete();
            hist_b.delete();
            mo_a = 1'b0; mo_b = 1'b0; mc_a = 0; mc_b = 0;
        end else begin
            s = sync_q[SYNC-1];
            sync_q.push_front(i);
            void'(sync_q.pop_back());

            hist_a.push_back(s);
            if (hist_a.size() > DEB_A) void'(hist_a.pop_front());
            n = run_len(hist_a, mo_a);
            if (n >= DEB_A) begin
                mo_a = !mo_a; mr_a = EDGES && mo_a; mf_a = EDGES && !mo_a; mc_a = 0;
            end else begin
                mc_a = n;
            end

            hist_b.push_back(s);
            if (hist_b.size() > DEB_B) void'(hist_b.pop_front());
            n = run_len(hist_b, mo_b);
            if (n >= DEB_B) begin
                mo_b = !mo_b; mr_b = EDGES && mo_b; mf_b = EDGES && !mo_b; mc_b = 0;
            end else begin
                mc_b = n;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("o_a",    32'(o_a),    32'(mo_a));
        check("rise_a", 32'(rise_a), 32'(mr_a));
        check("fall_a", 32'(fall_a), 32'(mf_a));
        check("cnt_a",  32'(dut_a.r_cnt), 32'(mc_a));
        check("o_b",    32'(o_b),    32'(mo_b));
        check("rise_b", 32'(rise_b), 32'(mr_b));
        check("fall_b", 32'(fall_b), 32'(mf_b));
        check("cnt_b",  32'(dut_b.r_cnt), 32'(mc_b));
    endtask

    task automatic step(input bit r, input bit i);
        RESET = r;
        I     = i;
        @(posedge CLK);
        model_edge(r, i);
        #1;
        check_all();
    endtask

    initial begin
        int  n;
        int  first_b;
        bit  saw_rise;
        bit  v;
        int  len;

        RESET = 1'b1;
        I     = 1'b0;

        // Reset for three cycles with arbitrary I.
        repeat (3) step(1'b1, 1'(($urandom_range(0, 1))));

        // Held 1: O_a rises 5 edges after the first edge sampling I=1, O_b after 2.
        n = 0; first_b = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
            if (o_b && first_b == 0) first_b = n;
        end while (!o_a && n < 12);
        check("lat025", 32'(n - 1), 32'd5);
        check("lat030", 32'(first_b - 1), 32'd2);
        repeat (3) step(1'b0, 1'b1);

        // Held 0 from O=1: single FALL after 5 edges, then 2-cycle chatter.
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (o_a && n < 12);
        check("lat027", 32'(n - 1), 32'd5);
        for (int k = 0; k < 20; k++) step(1'b0, 1'((k / 2) % 2 == 0));
        check("hold027", 32'(o_a), 32'd0);
        repeat (4) step(1'b0, 1'b0);

        // Three-cycle bounce to 1: O_a never moves.
        saw_rise = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'(k < 3));
            if (rise_a || o_a) saw_rise = 1'b1;
        end
        check("bounce026", 32'(saw_rise), 32'd0);
        check("cnt026", 32'(dut_a.r_cnt), 32'd0);

        // Reset while the 0->1 counter sits at 2, I kept 1.
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (mc_a != 2 && n < 10);
        check("cnt028", 32'(dut_a.r_cnt), 32'd2);
        step(1'b1, 1'b1);
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (!o_a && n < 12);
        check("lat028", 32'(n), 32'd6);
        check("rise028", 32'(rise_a), 32'(EDGES));

        // Random hold lengths with occasional resets.
        for (int k = 0; k < 80; k++) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            repeat (len) step(1'($urandom_range(0, 59) == 0), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
